sig_delay_line: RTL and testbench
=================================

# sig_delay_line

Parametrised circular-buffer delay line for the signal-generator datapath, built on a simple dual-port sample memory. Each enabled cycle it stores one input sample and returns the sample written `offset` enables earlier, with wrap-around addressing. It adds the following over the plain two-port RAM:
- a write-pointer counter
- history-fill tracking
- an output-valid strobe
- zero-delay bypass
- optional zero-fill of unwritten history

It sits between the sample source (ROM/counter path) and the DAC/output stage, providing a runtime-programmable phase or time offset.

## Interface
- `DATA_WIDTH`, default 8: sample width in bits.
- `ADDR_WIDTH`, default 9: buffer address width; `DEPTH = 2**ADDR_WIDTH` samples.
- `clk`  input  1: single clock; all logic samples on the rising edge.
- `rst_n`  input  1: synchronous, active-low reset.
- `en`  input  1: sample strobe; one write and one read per asserted cycle.
- `din`  input  `DATA_WIDTH`: sample to store.
- `offset`  input  `ADDR_WIDTH`: delay in enabled samples, 0 to DEPTH-1; sampled only when `en`=1.
- `dout`  output  `DATA_WIDTH`: delayed sample, registered.
- `dout_valid`  output  1: one-cycle pulse, high in the cycle after each `en`.
- `hist_ok`  output  1: registered with `dout`; high when the requested delay was covered by written history.

## Operation
- State:
  - `wr_ptr`, `ADDR_WIDTH` bits.
  - `fill`, `ADDR_WIDTH+1` bits, saturating at DEPTH.
  - Output registers `dout`, `dout_valid`, `hist_ok`.
  - Registered bypass copy of `din`.
- On `en`=1:
  - Write `din` to `mem[wr_ptr]`.
  - `wr_ptr` <= `wr_ptr+1`, modulo DEPTH (natural wrap).
  - `fill` <= min(`fill+1`, DEPTH).
- Read address: `rd_addr = wr_ptr - offset`, modulo DEPTH, using the pre-increment `wr_ptr`. The read is issued in the same cycle as the write.
- `offset`=0 is bypass: `dout` takes `din` of the same enable. The memory read at the write address is ignored; there is no read-during-write hazard.
- `offset`≥1: `dout` takes the memory word; write and read addresses never collide.
- `hist_ok` = (`offset` ≤ `fill` before the increment). `offset`=0 always gives `hist_ok`=1.
- `en`=0:
  - No write, no pointer or fill change.
  - `dout` and `hist_ok` hold.
  - `dout_valid` = 0.
- `offset` may change on any enable; it takes effect for that enable. There is no settling period.
- Memory contents are not reset.

## Timing
- Latency: 1 cycle from `en` to `dout` and `dout_valid`.
- Throughput: one sample per cycle with `en` held high.
- Reset values: `dout`=0, `dout_valid`=0, `hist_ok`=0, `wr_ptr`=0, `fill`=0.
- Reset takes priority over `en` in the same cycle; that sample is dropped.
- Reset mid-stream: the pointer restarts at 0 and history is treated as empty. Old memory words are not used while `hist_ok`=0, except as governed by the macro below.
- Full buffer: `fill` stays at DEPTH and writes overwrite the oldest samples. `offset`=DEPTH-1 returns the oldest retained sample.

## Configuration
- `SIG_DELAY_ZERO_FILL_EN` defined: when `hist_ok` would be 0, `dout` is forced to 0. This gives a clean leading silence after reset.
- Not defined: `dout` is the raw memory word, undefined after power-up and stale after reset. `hist_ok` still reports correctly. This saves the output mux.

## Structure
- Package `sig_delay_pkg` holds:
  - default `DATA_WIDTH`/`ADDR_WIDTH` constants;
  - a `delay_mode_e` typedef (BYPASS, MEMORY) for the registered read-source select.
- One sub-module, `sdp_ram`: parametrised simple dual-port memory with write enable, read enable and registered read (read-old-data). Instantiate it with `rd_en = en`.

## Test plan
All scenarios use `ADDR_WIDTH`=4 (DEPTH 16), `DATA_WIDTH`=8 and `SIG_DELAY_ZERO_FILL_EN` defined.
- **Reset:** hold `rst_n`=0 for 3 cycles with `en`=1 and `din`=0xAA. Required: `dout`=0, `dout_valid`=0, `hist_ok`=0 throughout.
- **Ramp, offset 3:** `din`=1..20 on consecutive enables.
  - Enables 1–3 give `dout`=0, `hist_ok`=0.
  - Enable k≥4 gives `dout`=k-3, `hist_ok`=1, one cycle later.
- **Bypass, offset 0:** `din`=0x5C. Required next cycle: `dout`=0x5C, `hist_ok`=1, including on the first enable after reset.
- **Wrap:** 40 ramp samples with `offset`=15. Enable k≥16 gives `dout`=k-15, checked across the pointer wrap at k=17 and k=33.
- **Gapped enable:** `en` every other cycle with `offset`=1.
  - `dout_valid` pulses only in cycles after `en`.
  - `dout` holds during gaps.
  - Delay counts enables, not cycles.
- **Reset mid-stream:** after 10 samples, pulse `rst_n` low for 1 cycle, then continue with `offset`=2. The next 2 enables give `dout`=0, `hist_ok`=0; the third returns the first post-reset sample.

Source files
------------

// File: rtl/sig_delay_pkg.sv
// sig_delay_pkg: default widths and the read-source select shared by the delay line.
package sig_delay_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 9;
    typedef enum logic {BYPASS = 1'b0, MEMORY = 1'b1} delay_mode_e;
endpackage

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port memory, one write port and one registered read port (read-old-data).
module sdp_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/sig_delay_line.sv
// sig_delay_line: circular-buffer delay line returning the sample written i_offset enables earlier.
// Define SIG_DELAY_ZERO_FILL_EN to force o_dout to 0 whenever the requested history is not yet written.
module sig_delay_line
    import sig_delay_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic [ADDR_WIDTH-1:0] i_offset,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_dout_valid,
    output logic                  o_hist_ok
);
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_fill;
    logic [DATA_WIDTH-1:0] r_byp;
    delay_mode_e           r_mode;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [DATA_WIDTH-1:0] w_mem_dout;
    logic [DATA_WIDTH-1:0] w_byp;
    delay_mode_e           w_mode;
    logic                  w_hist_ok;
    logic                  w_we;
    assign w_rd_addr = r_wr_ptr - i_offset;
    assign w_hist_ok = {1'b0, i_offset} <= r_fill;
    assign w_we      = i_en & i_rst_n;
`ifdef SIG_DELAY_ZERO_FILL_EN
    // Missing history is served as a zero routed through the bypass register.
    assign w_mode = (i_offset != '0 && w_hist_ok) ? MEMORY : BYPASS;
    assign w_byp  = (i_offset == '0) ? i_din : '0;
`else
    assign w_mode = (i_offset == '0) ? BYPASS : MEMORY;
    assign w_byp  = i_din;
`endif
    sdp_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_din),
        .i_re    (i_en),
        .i_raddr (w_rd_addr),
        .o_rdata (w_mem_dout)
    );
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr     <= '0;
            r_fill       <= '0;
            r_byp        <= '0;
            r_mode       <= BYPASS;
            o_dout_valid <= 1'b0;
            o_hist_ok    <= 1'b0;
        end else begin
            o_dout_valid <= i_en;
            if (i_en) begin
                r_wr_ptr  <= r_wr_ptr + 1'b1;
                r_fill    <= r_fill + {{ADDR_WIDTH{1'b0}}, r_fill != FULL};
                r_byp     <= w_byp;
                r_mode    <= w_mode;
                o_hist_ok <= w_hist_ok;
            end
        end
    end
    assign o_dout = (r_mode == MEMORY) ? w_mem_dout : r_byp;
endmodule

// File: tb/tb_sig_delay_line.sv
// tb_sig_delay_line: directed table plus hand sequences for the delay line at DEPTH 16.
module tb_sig_delay_line;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] din = '0;
    logic [3:0] offset = '0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       hist_ok;
    int         errors = 0;
    int         checks = 0;
    bit         zf;

    typedef struct {
        logic       en;
        logic [7:0] din;
        logic [3:0] off;
        logic       valid;
        logic [7:0] dout;
        logic       hist;
    } vec_t;
    vec_t tbl [8];

    sig_delay_line #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_din        (din),
        .i_offset     (offset),
        .o_dout       (dout),
        .o_dout_valid (dout_valid),
        .o_hist_ok    (hist_ok)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic e, input logic [7:0] d, input logic [3:0] o);
        @(negedge clk);
        rst_n = r;
        en = e;
        din = d;
        offset = o;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic v, input logic [7:0] d, input logic h);
        chk({name, ".valid"}, dout_valid, v);
        chk({name, ".hist"}, hist_ok, h);
        // Without zero-fill the word behind a missing history is undefined.
        if (h || zf) chk({name, ".dout"}, dout, d);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 8'h00, 4'd0);
        step(1'b0, 1'b0, 8'h00, 4'd0);
    endtask

    initial begin
`ifdef SIG_DELAY_ZERO_FILL_EN
        zf = 1'b1;
`else
        zf = 1'b0;
`endif
        tbl[0] = '{1'b1, 8'h5C, 4'd0, 1'b1, 8'h5C, 1'b1};
        tbl[1] = '{1'b0, 8'h11, 4'd0, 1'b0, 8'h5C, 1'b1};
        tbl[2] = '{1'b1, 8'h22, 4'd1, 1'b1, 8'h5C, 1'b1};
        tbl[3] = '{1'b1, 8'h33, 4'd3, 1'b1, 8'h00, 1'b0};
        tbl[4] = '{1'b0, 8'h99, 4'd0, 1'b0, 8'h00, 1'b0};
        tbl[5] = '{1'b1, 8'h44, 4'd2, 1'b1, 8'h22, 1'b1};
        tbl[6] = '{1'b1, 8'h55, 4'd0, 1'b1, 8'h55, 1'b1};
        tbl[7] = '{1'b1, 8'h66, 4'd4, 1'b1, 8'h22, 1'b1};

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'hAA, 4'd0);
            chk("reset.dout", dout, 0);
            chk("reset.valid", dout_valid, 0);
            chk("reset.hist", hist_ok, 0);
        end

        for (int i = 0; i < 8; i++) begin
            step(1'b1, tbl[i].en, tbl[i].din, tbl[i].off);
            chk_out($sformatf("table[%0d]", i), tbl[i].valid, tbl[i].dout, tbl[i].hist);
        end

        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b1, 8'(k), 4'd3);
            chk_out($sformatf("ramp[%0d]", k), 1'b1, (k >= 4) ? 8'(k - 3) : 8'h00, k >= 4);
        end

        do_reset();
        for (int k = 1; k <= 40; k++) begin
            step(1'b1, 1'b1, 8'(k), 4'd15);
            chk_out($sformatf("wrap[%0d]", k), 1'b1, (k >= 16) ? 8'(k - 15) : 8'h00, k >= 16);
        end

        do_reset();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1, 8'(i * 3), 4'd1);
            chk_out($sformatf("gap_en[%0d]", i), 1'b1, (i >= 2) ? 8'((i - 1) * 3) : 8'h00, i >= 2);
            step(1'b1, 1'b0, 8'hFF, 4'd0);
            chk_out($sformatf("gap_idle[%0d]", i), 1'b0, (i >= 2) ? 8'((i - 1) * 3) : 8'h00, i >= 2);
        end

        do_reset();
        for (int i = 1; i <= 10; i++) step(1'b1, 1'b1, 8'(8'h80 + i), 4'd0);
        chk_out("pre_rst", 1'b1, 8'h8A, 1'b1);
        step(1'b0, 1'b1, 8'hEE, 4'd2);
        chk("mid_rst.dout", dout, 0);
        chk("mid_rst.valid", dout_valid, 0);
        chk("mid_rst.hist", hist_ok, 0);
        for (int j = 1; j <= 5; j++) begin
            step(1'b1, 1'b1, 8'(8'hA0 + j), 4'd2);
            chk_out($sformatf("post_rst[%0d]", j), 1'b1, (j >= 3) ? 8'(8'hA0 + j - 2) : 8'h00, j >= 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
